// File: rtl/spi_flash_loader.sv
// spi_flash_loader: issues a flash READ over a byte-level SPI engine and streams the data into a local RAM port.
// Optional: define SPI_FLASH_FAST_READ_EN for FAST READ (0x0B plus one dummy byte after the address).
module spi_flash_loader #(
  parameter int WR_ADDR_W = 14,
  parameter int LEN_W     = 16,
  parameter int CS_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [23:0]          flash_addr,
  input  logic [WR_ADDR_W-1:0] wr_base,
  input  logic [LEN_W-1:0]     length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 cs_n,
  output logic                 spi_start,
  output logic [7:0]           spi_tx,
  input  logic [7:0]           spi_rx,
  input  logic                 spi_new_data,
  output logic                 wr_en,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic [7:0]           wr_data
);

  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_GAP - 1);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam logic [2:0] HDR = 3'd5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam logic [2:0] HDR = 3'd4;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [2:0]           idx_q, idx_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [WR_ADDR_W-1:0] ptr_q, ptr_d;
  logic [23:0]          faddr_q, faddr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cs_n_q, cs_n_d;
  logic                 spi_start_q, spi_start_d;
  logic [7:0]           spi_tx_q, spi_tx_d;
  logic                 wr_en_q, wr_en_d;
  logic [WR_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;

  logic [7:0]           seq_byte;
  logic                 is_read;
  logic                 is_last;

  // idx saturates at HDR: every byte from there on is a read byte (and any dummy byte sits below HDR)
  always_comb begin
    seq_byte = 8'h00;
    case (idx_q)
      3'd0:    seq_byte = CMD;
      3'd1:    seq_byte = faddr_q[23:16];
      3'd2:    seq_byte = faddr_q[15:8];
      3'd3:    seq_byte = faddr_q[7:0];
      default: seq_byte = 8'h00;
    endcase
  end

  assign is_read = (idx_q == HDR);
  assign is_last = is_read && (rem_q == LEN_W'(1));

  // Transaction sequencing and next values for every registered output
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    ptr_d       = ptr_q;
    faddr_d     = faddr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    spi_start_d = 1'b0;
    spi_tx_d    = spi_tx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      IDLE: begin
        if (go && (length != '0)) begin
          faddr_d = flash_addr;
          ptr_d   = wr_base;
          rem_d   = length;
          idx_d   = 3'd0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          gap_d   = GAP_INIT;
          state_d = SETUP;
        end else if (go) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (abort) begin
          gap_d   = GAP_INIT;
          state_d = HOLD;
        end else if (gap_q == '0) begin
          idx_d   = 3'd0;
          state_d = SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      SEND: begin
        spi_start_d = 1'b1;
        spi_tx_d    = seq_byte;
        state_d     = WAIT;
      end
      WAIT: begin
        if (spi_new_data) begin
          if (is_read) begin
            wr_en_d   = 1'b1;
            wr_data_d = spi_rx;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_q + WR_ADDR_W'(1);
            rem_d     = rem_q - LEN_W'(1);
          end else begin
            idx_d = idx_q + 3'd1;
          end
          if (is_last || abort) begin
            gap_d   = GAP_INIT;
            state_d = HOLD;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (gap_q == '0) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      idx_q       <= 3'd0;
      rem_q       <= '0;
      ptr_q       <= '0;
      faddr_q     <= 24'h000000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      ptr_q       <= ptr_d;
      faddr_q     <= faddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      spi_start_q <= spi_start_d;
      spi_tx_q    <= spi_tx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cs_n      = cs_n_q;
  assign spi_start = spi_start_q;
  assign spi_tx    = spi_tx_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: a randomized byte-engine responder plus a transaction-level model.
// Honours SPI_FLASH_FAST_READ_EN the same way the design does.
module tb_spi_flash_loader;
  localparam int GAP = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int HDR = 5;
  localparam logic [7:0] CMD = 8'h0B;
  logic [7:0] t1_tx[$] = '{8'h0B, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
`else
  localparam int HDR = 4;
  localparam logic [7:0] CMD = 8'h03;
  logic [7:0] t1_tx[$] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00};
`endif

  logic        clk = 1'b0;
  logic        rst, go, abort;
  logic [23:0] flash_addr;
  logic [13:0] wr_base;
  logic [15:0] length;
  logic        busy, done, cs_n, spi_start, wr_en;
  logic [7:0]  spi_tx, wr_data;
  logic [13:0] wr_addr;
  logic [7:0]  spi_rx = 8'h00;
  logic        spi_new_data = 1'b0;

  spi_flash_loader #(.WR_ADDR_W(14), .LEN_W(16), .CS_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .go(go), .flash_addr(flash_addr), .wr_base(wr_base),
    .length(length), .abort(abort), .busy(busy), .done(done), .cs_n(cs_n),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx),
    .spi_new_data(spi_new_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte engine stand-in: random latency, data from rx_plan or random
  logic [7:0] rx_plan[$];
  logic       eng_pend = 1'b0;
  int         eng_lat = 0;
  logic [7:0] eng_byte = 8'h00;
  always @(posedge clk) begin
    spi_new_data <= 1'b0;
    if (rst) begin
      eng_pend <= 1'b0;
      eng_lat  <= 0;
    end else if (eng_pend) begin
      if (eng_lat == 0) begin
        spi_new_data <= 1'b1;
        spi_rx       <= eng_byte;
        eng_pend     <= 1'b0;
      end else begin
        eng_lat <= eng_lat - 1;
      end
    end else if (spi_start) begin
      eng_pend <= 1'b1;
      eng_lat  <= int'($urandom_range(3, 0));
      if (rx_plan.size() > 0) eng_byte <= rx_plan.pop_front();
      else eng_byte <= 8'($urandom);
    end
  end

  // Transaction-level model
  typedef struct { logic [13:0] a; logic [7:0] d; } wr_t;
  logic [23:0] m_addr = 24'h0;
  logic [13:0] m_base = 14'h0;
  int m_exp_bytes = 0, m_exp_wr = 0;
  int sent = 0, nd_cnt = 0, wr_cnt = 0, low_run = 0, since_nd = 0, dones = 0;
  bit saw_nd = 0, prev_cs_n = 1, wr_due = 0;
  wr_t exp_wr[$];
  wr_t wr_log[$];
  wr_t cw;
  logic [7:0] tx_log[$];

  function automatic logic [7:0] seq_byte(input int n, input logic [23:0] a);
    if (n == 0) return CMD;
    else if (n == 1) return a[23:16];
    else if (n == 2) return a[15:8];
    else if (n == 3) return a[7:0];
    else return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sent = 0; nd_cnt = 0; wr_cnt = 0; low_run = 0; since_nd = 0;
      saw_nd = 0; prev_cs_n = 1; wr_due = 0;
      exp_wr.delete();
    end else begin
      if (cs_n) low_run = 0;
      else low_run++;
      if (spi_start) begin
        check("start_cs_low", cs_n, 0);
        check("start_busy", busy, 1);
        if (sent == 0) check("cs_setup", low_run > GAP, 1);
        check("spi_tx", spi_tx, seq_byte(sent, m_addr));
        tx_log.push_back(spi_tx);
        sent++;
      end
      if (wr_en || wr_due) check("wr_timing", wr_en, wr_due);
      if (wr_en && exp_wr.size() > 0) begin
        cw = exp_wr.pop_front();
        check("wr_addr", wr_addr, cw.a);
        check("wr_data", wr_data, cw.d);
      end
      if (wr_en) begin
        cw.a = wr_addr; cw.d = wr_data;
        wr_log.push_back(cw);
        wr_cnt++;
      end
      wr_due = 0;
      if (spi_new_data) begin
        if (nd_cnt >= HDR) begin
          cw.a = m_base + 14'(nd_cnt - HDR);
          cw.d = spi_rx;
          exp_wr.push_back(cw);
          wr_due = 1;
        end
        nd_cnt++; saw_nd = 1; since_nd = 0;
      end else if (!cs_n) begin
        since_nd++;
      end
      if (cs_n && !prev_cs_n && saw_nd) check("cs_hold", since_nd >= GAP, 1);
      if (done) begin
        check("done_busy", busy, 0);
        check("bytes_sent", sent, m_exp_bytes);
        check("bytes_done", nd_cnt, m_exp_bytes);
        check("write_count", wr_cnt, m_exp_wr);
        dones++;
        sent = 0; nd_cnt = 0; wr_cnt = 0; saw_nd = 0;
      end
      prev_cs_n = cs_n;
    end
  end

  task automatic start_go(input logic [23:0] a, input logic [13:0] b, input logic [15:0] n);
    m_addr = a; m_base = b;
    m_exp_bytes = (n == 0) ? 0 : HDR + int'(n);
    m_exp_wr = int'(n);
    flash_addr = a; wr_base = b; length = n; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("go_busy", busy, (n != 0));
    check("go_cs_n", cs_n, (n == 0));
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check({name, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_sent(input int target);
    for (int k = 0; k < 3000 && sent < target; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int d0, j, n, mode;
    logic [23:0] a;
    logic [13:0] b;
    rst = 1'b1; go = 1'b0; abort = 1'b0; flash_addr = 24'h0; wr_base = 14'h0; length = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", spi_start, 0);
    check("rst_tx", spi_tx, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic read with known flash data
    for (int i = 0; i < HDR; i++) rx_plan.push_back(8'hFF);
    rx_plan.push_back(8'hA1); rx_plan.push_back(8'hB2); rx_plan.push_back(8'hC3);
    tx_log.delete(); wr_log.delete(); d0 = dones;
    start_go(24'h012345, 14'h0100, 16'd3);
    wait_done("t1");
    check("t1_dones", dones - d0, 1);
    check("t1_tx_count", tx_log.size(), t1_tx.size());
    for (int i = 0; i < t1_tx.size() && i < tx_log.size(); i++) check("t1_tx_byte", tx_log[i], t1_tx[i]);
    check("t1_wr_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("t1_wr0_a", wr_log[0].a, 14'h0100); check("t1_wr0_d", wr_log[0].d, 8'hA1);
      check("t1_wr1_a", wr_log[1].a, 14'h0101); check("t1_wr1_d", wr_log[1].d, 8'hB2);
      check("t1_wr2_a", wr_log[2].a, 14'h0102); check("t1_wr2_d", wr_log[2].d, 8'hC3);
    end

    // Zero length: done next cycle, nothing else moves
    tx_log.delete(); d0 = dones;
    start_go(24'hABCDEF, 14'h0010, 16'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    @(posedge clk); #1;
    check("len0_done_pulse", done, 0);
    check("len0_dones", dones - d0, 1);
    check("len0_no_start", tx_log.size(), 0);

    // Destination address wrap
    wr_log.delete();
    start_go(24'h000100, 14'h3FFF, 16'd2);
    wait_done("wrap");
    check("wrap_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("wrap_a0", wr_log[0].a, 14'h3FFF);
      check("wrap_a1", wr_log[1].a, 14'h0000);
    end

    // Single read byte lands the first byte after the header
    for (int i = 0; i < HDR; i++) rx_plan.push_back(8'hEE);
    rx_plan.push_back(8'h5A);
    wr_log.delete(); tx_log.delete();
    start_go(24'h0A0B0C, 14'h0200, 16'd1);
    wait_done("one");
    check("one_tx_count", tx_log.size(), HDR + 1);
    check("one_wr_count", wr_log.size(), 1);
    if (wr_log.size() == 1) check("one_wr_data", wr_log[0].d, 8'h5A);

    // Abort during the second read byte, then a normal run
    wr_log.delete();
    start_go(24'h111111, 14'h0300, 16'd10);
    m_exp_bytes = HDR + 2; m_exp_wr = 2;
    wait_sent(HDR + 2);
    abort = 1'b1;
    wait_done("abort");
    abort = 1'b0;
    check("abort_wr_count", wr_log.size(), 2);
    check("abort_cs_n", cs_n, 1);
    start_go(24'h222222, 14'h0400, 16'd4);
    wait_done("after_abort");

    // Reset in the middle of the address bytes, then a normal run
    start_go(24'h333333, 14'h0500, 16'd6);
    wait_sent(2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", wr_en, 0);
    rst = 1'b0; rx_plan.delete();
    @(posedge clk); #1;
    start_go(24'h444444, 14'h0600, 16'd5);
    wait_done("after_rst");

    // Randomized transactions
    for (int it = 0; it < 30; it++) begin
      a = 24'($urandom); b = 14'($urandom);
      n = int'($urandom_range(12, 0)); mode = int'($urandom_range(3, 0));
      if (n == 0) begin
        start_go(a, b, 16'(n));
        wait_done("rnd_len0");
      end else if (mode == 0) begin
        j = int'($urandom_range(HDR + n - 1, 0));
        start_go(a, b, 16'(n));
        m_exp_bytes = j + 1;
        m_exp_wr = (j + 1 > HDR) ? j + 1 - HDR : 0;
        wait_sent(j + 1);
        abort = 1'b1;
        wait_done("rnd_abort");
        abort = 1'b0;
      end else if (mode == 1) begin
        start_go(a, b, 16'(n));
        abort = 1'b1;
        m_exp_bytes = 0; m_exp_wr = 0;
        wait_done("rnd_setup_abort");
        abort = 1'b0;
      end else begin
        start_go(a, b, 16'(n));
        if (mode == 2) begin
          wait_sent(1);
          flash_addr = 24'($urandom); wr_base = 14'($urandom); length = 16'd0;
          go = 1'b1;
          @(posedge clk); #1;
          go = 1'b0;
        end
        wait_done("rnd_normal");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
